// File: rtl/ex_pkg.sv
// Shared definitions for the execute stage: ALU opcode encodings, the
// multi-cycle predicate, FSM states, forward-select codes and the bundle
// of control bits that travel alongside an instruction into EX/MEM.
package ex_pkg;

  // ALU opcode encodings; bit 4 marks the multiply/divide group.
  localparam int unsigned OP_ADD   = 0;
  localparam int unsigned OP_SUB   = 1;
  localparam int unsigned OP_AND   = 2;
  localparam int unsigned OP_OR    = 3;
  localparam int unsigned OP_XOR   = 4;
  localparam int unsigned OP_SLT   = 5;
  localparam int unsigned OP_SLTU  = 6;
  localparam int unsigned OP_SLL   = 7;
  localparam int unsigned OP_SRL   = 8;
  localparam int unsigned OP_SRA   = 9;
  localparam int unsigned OP_MUL   = 16;
  localparam int unsigned OP_MULHU = 17;
  localparam int unsigned OP_DIVU  = 18;
  localparam int unsigned OP_REMU  = 19;

  // Operand forward-select codes; FWD_RSVD falls back to the ID/EX value.
  localparam logic [1:0] FWD_ID   = 2'd0;
  localparam logic [1:0] FWD_MEM  = 2'd1;
  localparam logic [1:0] FWD_WB   = 2'd2;
  localparam logic [1:0] FWD_RSVD = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_DONE
  } ex_state_e;

  // Low two opcode bits of the multi-cycle group select the operation;
  // bit 0 picks the high half (MULHU) or the remainder (REMU).
  typedef enum logic [1:0] {
    MD_MUL,
    MD_MULHU,
    MD_DIVU,
    MD_REMU
  } md_op_e;

  // What the EX/MEM register does on the next edge.
  typedef enum logic [1:0] {
    EXM_HOLD,
    EXM_BUBBLE,
    EXM_ALU,
    EXM_MD
  } exm_act_e;

  typedef struct packed {
    logic branch;
    logic mem_read;
    logic mem_write;
    logic mem_to_reg;
    logic reg_write;
  } ctrl_t;

  // Bit 4 set selects the multiply/divide group; only its four defined
  // members go multi-cycle so that undefined codes stay single-cycle (result 0).
  function automatic logic is_multicycle(input logic [31:0] op);
    return (op >= OP_MUL) && (op <= OP_REMU);
  endfunction

endpackage

// File: rtl/ex_muldiv_iter.sv
// Iterative unsigned multiply/divide: one result bit per cycle for DATA_W
// cycles. start captures operands; done is high during the final step; the
// result is stable from the edge after done until the next start.
// Division by zero needs no special case: every trial subtraction succeeds,
// giving an all-ones quotient and leaving the dividend as the remainder.
module ex_muldiv_iter
  import ex_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  md_op_e            op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              done,
  output logic [DATA_W-1:0] result
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

  logic [CNT_W-1:0]  cnt;
  logic              running;
  md_op_e            op_q;
  logic [DATA_W-1:0] hi;    // product high half / partial remainder
  logic [DATA_W-1:0] lo;    // multiplier -> product low half / dividend -> quotient
  logic [DATA_W-1:0] opnd;  // multiplicand / divisor

  logic [DATA_W:0]   mul_sum;
  logic [DATA_W:0]   div_shift;
  logic              div_ge;
  logic [DATA_W-1:0] div_next;

  // One shift-add or restoring-divide step on the current registers.
  always_comb begin
    mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
    div_shift = {hi, lo[DATA_W-1]};
    div_ge    = div_shift >= {1'b0, opnd};
    div_next  = DATA_W'(div_ge ? div_shift - {1'b0, opnd} : div_shift);
  end

  // Operand capture, per-cycle iteration and the step counter.
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would chain steps within a single edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      // NOTE: datapath registers are reset too; it costs little here and keeps
      // the held result deterministic straight out of reset.
      cnt     <= '0;
      running <= 1'b0;
      op_q    <= MD_MUL;
      hi      <= '0;
      lo      <= '0;
      opnd    <= '0;
    end else if (abort) begin
      cnt     <= '0;
      running <= 1'b0;
    end else if (start) begin
      op_q    <= op;
      hi      <= '0;
      lo      <= a;
      opnd    <= b;
      cnt     <= '0;
      running <= 1'b1;
    end else if (running) begin
      if (op_q[1]) begin
        hi <= div_next;
        lo <= {lo[DATA_W-2:0], div_ge};
      end else begin
        hi <= mul_sum[DATA_W:1];
        lo <= {mul_sum[0], lo[DATA_W-1:1]};
      end
      if (cnt == LAST) begin
        cnt     <= '0;
        running <= 1'b0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign done   = running && (cnt == LAST);
  assign result = op_q[0] ? hi : lo;

endmodule

// File: rtl/ex_stage_mc.sv
// Execute stage with operand forwarding, valid/ready handshake, flush and an
// iterative multiply/divide unit; owns the EX/MEM pipeline register.
// Build option: define EX_FWD_EN to enable the FwdA/FwdB operand muxes;
// without it operands come from ID/EX only and the forwarding ports are unused.
module ex_stage_mc
  import ex_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int REG_AW  = 5,
  parameter int ALUOP_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               id_valid,
  output logic               id_ready,
  input  logic [DATA_W-1:0]  ID_EX_ReadData1,
  input  logic [DATA_W-1:0]  ID_EX_ReadData2,
  input  logic [DATA_W-1:0]  ID_EX_SignExtImm,
  input  logic [REG_AW-1:0]  ID_EX_Rb,
  input  logic [REG_AW-1:0]  ID_EX_Rd,
  input  logic               ID_EX_RegDst,
  input  logic               ID_EX_ALUSrc,
  input  logic [ALUOP_W-1:0] ID_EX_ALUOp,
  input  logic               ID_EX_Branch,
  input  logic               ID_EX_MemRead,
  input  logic               ID_EX_MemWrite,
  input  logic               ID_EX_MemToReg,
  input  logic               ID_EX_RegWrite,
  input  logic [1:0]         FwdA,
  input  logic [1:0]         FwdB,
  input  logic [DATA_W-1:0]  MEM_FwdData,
  input  logic [DATA_W-1:0]  WB_FwdData,
  input  logic               mem_stall,
  input  logic               flush,
  output logic               EX_MEM_Valid,
  output logic [DATA_W-1:0]  EX_MEM_ALUResult,
  output logic [DATA_W-1:0]  EX_MEM_ReadData2,
  output logic [REG_AW-1:0]  EX_MEM_WriteReg,
  output logic               EX_MEM_Zero,
  output logic               EX_MEM_Branch,
  output logic               EX_MEM_MemRead,
  output logic               EX_MEM_MemWrite,
  output logic               EX_MEM_MemToReg,
  output logic               EX_MEM_RegWrite,
  output logic               busy
);

  localparam int SH_W = $clog2(DATA_W);

  ex_state_e         state, state_next;
  exm_act_e          exm_act;
  logic [DATA_W-1:0] a_fwd, b_fwd, b_op, alu_res, md_result;
  logic [SH_W-1:0]   shamt;
  logic              is_mc, accept, md_done;
  logic [REG_AW-1:0] write_reg_sel;
  ctrl_t             ctrl_in;

  // Multi-cycle instruction context captured at accept.
  ctrl_t             mc_ctrl;
  logic [REG_AW-1:0] mc_wreg;
  logic [DATA_W-1:0] mc_rd2;

  // EX/MEM register contents.
  logic              exm_valid;
  logic [DATA_W-1:0] exm_result, exm_rd2;
  logic [REG_AW-1:0] exm_wreg;
  logic              exm_zero;
  ctrl_t             exm_ctrl;

`ifdef EX_FWD_EN
  // Operand forwarding muxes; the reserved code behaves like ID/EX.
  always_comb begin
    case (FwdA)
      FWD_MEM: a_fwd = MEM_FwdData;
      FWD_WB:  a_fwd = WB_FwdData;
      default: a_fwd = ID_EX_ReadData1;
    endcase
    case (FwdB)
      FWD_MEM: b_fwd = MEM_FwdData;
      FWD_WB:  b_fwd = WB_FwdData;
      default: b_fwd = ID_EX_ReadData2;
    endcase
  end
`else
  assign a_fwd = ID_EX_ReadData1;
  assign b_fwd = ID_EX_ReadData2;
  logic unused_fwd;
  assign unused_fwd = ^{FwdA, FwdB, MEM_FwdData, WB_FwdData};
`endif

  assign b_op          = ID_EX_ALUSrc ? ID_EX_SignExtImm : b_fwd;
  assign shamt         = b_op[SH_W-1:0];
  assign write_reg_sel = ID_EX_RegDst ? ID_EX_Rd : ID_EX_Rb;
  assign is_mc         = is_multicycle(32'(ID_EX_ALUOp));
  assign ctrl_in       = '{branch:     ID_EX_Branch,
                           mem_read:   ID_EX_MemRead,
                           mem_write:  ID_EX_MemWrite,
                           mem_to_reg: ID_EX_MemToReg,
                           reg_write:  ID_EX_RegWrite};

  // Handshake: only an idle, unstalled, unflushed stage out of reset accepts.
  assign id_ready = rst && (state == ST_IDLE) && !mem_stall && !flush;
  assign accept   = id_valid && id_ready;
  assign busy     = (state != ST_IDLE);

  // Single-cycle ALU; undefined opcodes produce 0.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    alu_res = '0;
    case (ID_EX_ALUOp)
      ALUOP_W'(OP_ADD):  alu_res = a_fwd + b_op;
      ALUOP_W'(OP_SUB):  alu_res = a_fwd - b_op;
      ALUOP_W'(OP_AND):  alu_res = a_fwd & b_op;
      ALUOP_W'(OP_OR):   alu_res = a_fwd | b_op;
      ALUOP_W'(OP_XOR):  alu_res = a_fwd ^ b_op;
      ALUOP_W'(OP_SLT):  alu_res = DATA_W'($signed(a_fwd) < $signed(b_op));
      ALUOP_W'(OP_SLTU): alu_res = DATA_W'(a_fwd < b_op);
      ALUOP_W'(OP_SLL):  alu_res = a_fwd << shamt;
      ALUOP_W'(OP_SRL):  alu_res = a_fwd >> shamt;
      ALUOP_W'(OP_SRA):  alu_res = $signed(a_fwd) >>> shamt;
      default:           alu_res = '0;
    endcase
  end

  ex_muldiv_iter #(
    .DATA_W (DATA_W)
  ) u_muldiv (
    .clk    (clk),
    .rst    (rst),
    .start  (accept && is_mc),
    .abort  (flush),
    .op     (md_op_e'(ID_EX_ALUOp[1:0])),
    .a      (a_fwd),
    .b      (b_op),
    .done   (md_done),
    .result (md_result)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_next;
  end

  // Next state and EX/MEM action; flush wins over mem_stall.
  always_comb begin
    state_next = state;
    exm_act    = EXM_BUBBLE;
    case (state)
      ST_IDLE: if (accept && is_mc) state_next = ST_BUSY;
      ST_BUSY: if (flush) state_next = ST_IDLE;
               else if (md_done) state_next = ST_DONE;
      ST_DONE: if (flush || !mem_stall) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
    if (flush)                   exm_act = EXM_BUBBLE;
    else if (state == ST_DONE)   exm_act = mem_stall ? EXM_HOLD : EXM_MD;
    else if (mem_stall)          exm_act = EXM_HOLD;
    else if (state == ST_BUSY)   exm_act = EXM_BUBBLE;
    else if (accept && !is_mc)   exm_act = EXM_ALU;
    else                         exm_act = EXM_BUBBLE;
  end

  // Capture destination and controls of a multi-cycle op at accept.
  always_ff @(posedge clk) begin
    if (!rst) begin
      mc_ctrl <= '0;
      mc_wreg <= '0;
      mc_rd2  <= '0;
    end else if (accept && is_mc) begin
      mc_ctrl <= ctrl_in;
      mc_wreg <= write_reg_sel;
      mc_rd2  <= b_fwd;
    end
  end

  // EX/MEM pipeline register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      exm_valid  <= 1'b0;
      exm_result <= '0;
      exm_rd2    <= '0;
      exm_wreg   <= '0;
      exm_zero   <= 1'b0;
      exm_ctrl   <= '0;
    end else begin
      case (exm_act)
        EXM_BUBBLE: begin
          exm_valid  <= 1'b0;
          exm_result <= '0;
          exm_rd2    <= '0;
          exm_wreg   <= '0;
          exm_zero   <= 1'b0;
          exm_ctrl   <= '0;
        end
        EXM_ALU: begin
          exm_valid  <= 1'b1;
          exm_result <= alu_res;
          exm_rd2    <= b_fwd;
          exm_wreg   <= write_reg_sel;
          exm_zero   <= (alu_res == '0);
          exm_ctrl   <= ctrl_in;
        end
        EXM_MD: begin
          exm_valid  <= 1'b1;
          exm_result <= md_result;
          exm_rd2    <= mc_rd2;
          exm_wreg   <= mc_wreg;
          exm_zero   <= (md_result == '0);
          exm_ctrl   <= mc_ctrl;
        end
        default: ;  // EXM_HOLD keeps the current contents
      endcase
    end
  end

  assign EX_MEM_Valid     = exm_valid;
  assign EX_MEM_ALUResult = exm_result;
  assign EX_MEM_ReadData2 = exm_rd2;
  assign EX_MEM_WriteReg  = exm_wreg;
  assign EX_MEM_Zero      = exm_zero;
  assign EX_MEM_Branch    = exm_ctrl.branch;
  assign EX_MEM_MemRead   = exm_ctrl.mem_read;
  assign EX_MEM_MemWrite  = exm_ctrl.mem_write;
  assign EX_MEM_MemToReg  = exm_ctrl.mem_to_reg;
  assign EX_MEM_RegWrite  = exm_ctrl.reg_write;

endmodule

// File: tb/tb_ex_stage_mc.sv
// Directed self-checking bench for ex_stage_mc (DATA_W = 32).
module tb_ex_stage_mc;

  localparam int DATA_W  = 32;
  localparam int REG_AW  = 5;
  localparam int ALUOP_W = 5;

  logic               clk, rst, id_valid, id_ready;
  logic [DATA_W-1:0]  rd1, rd2, imm;
  logic [REG_AW-1:0]  rb, rd;
  logic               regdst, alusrc;
  logic [ALUOP_W-1:0] aluop;
  logic               br, mrd, mwr, m2r, rwr;
  logic [1:0]         fwd_a, fwd_b;
  logic [DATA_W-1:0]  mem_fwd, wb_fwd;
  logic               mem_stall, flush;
  logic               v_out;
  logic [DATA_W-1:0]  res_out, rd2_out;
  logic [REG_AW-1:0]  wreg_out;
  logic               zero_out, br_out, mrd_out, mwr_out, m2r_out, rwr_out, busy;

  int n_cmp = 0;
  int n_bad = 0;

  ex_stage_mc #(
    .DATA_W (DATA_W), .REG_AW (REG_AW), .ALUOP_W (ALUOP_W)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .id_valid         (id_valid),
    .id_ready         (id_ready),
    .ID_EX_ReadData1  (rd1),
    .ID_EX_ReadData2  (rd2),
    .ID_EX_SignExtImm (imm),
    .ID_EX_Rb         (rb),
    .ID_EX_Rd         (rd),
    .ID_EX_RegDst     (regdst),
    .ID_EX_ALUSrc     (alusrc),
    .ID_EX_ALUOp      (aluop),
    .ID_EX_Branch     (br),
    .ID_EX_MemRead    (mrd),
    .ID_EX_MemWrite   (mwr),
    .ID_EX_MemToReg   (m2r),
    .ID_EX_RegWrite   (rwr),
    .FwdA             (fwd_a),
    .FwdB             (fwd_b),
    .MEM_FwdData      (mem_fwd),
    .WB_FwdData       (wb_fwd),
    .mem_stall        (mem_stall),
    .flush            (flush),
    .EX_MEM_Valid     (v_out),
    .EX_MEM_ALUResult (res_out),
    .EX_MEM_ReadData2 (rd2_out),
    .EX_MEM_WriteReg  (wreg_out),
    .EX_MEM_Zero      (zero_out),
    .EX_MEM_Branch    (br_out),
    .EX_MEM_MemRead   (mrd_out),
    .EX_MEM_MemWrite  (mwr_out),
    .EX_MEM_MemToReg  (m2r_out),
    .EX_MEM_RegWrite  (rwr_out),
    .busy             (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    aluop    = op;
    rd1      = a;
    rd2      = b;
    alusrc   = 1'b0;
    fwd_a    = 2'd0;
    fwd_b    = 2'd0;
    id_valid = 1'b1;
  endtask

  // Issue a multi-cycle op; returns cycles from accept edge to Valid and the
  // number of sampled cycles with id_ready low. Bounded at 60 cycles.
  task automatic run_mc(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output int low);
    set_op(op, a, b);
    tick();
    id_valid = 1'b0;
    lat = 0;
    low = 0;
    while (!v_out && lat < 60) begin
      if (!id_ready) low++;
      tick();
      lat++;
    end
  endtask

  // Single-cycle table: op, A, B, expected result.
  logic [4:0]  t_op  [11] = '{5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd0, 5'd12, 5'd1};
  logic [31:0] t_a   [11] = '{32'hF0F0, 32'hF0F0, 32'hFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1,
                              32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF, 32'd5, 32'd3};
  logic [31:0] t_b   [11] = '{32'hFF00, 32'h0F0F, 32'h0F, 32'd1, 32'd1, 32'd33,
                              32'd4, 32'd4, 32'd2, 32'd5, 32'd5};
  logic [31:0] t_exp [11] = '{32'hF000, 32'hFFFF, 32'hF0, 32'd1, 32'd0, 32'd2,
                              32'h0800_0000, 32'hF800_0000, 32'd1, 32'd0, 32'hFFFF_FFFE};

  logic [31:0] exp_sub, exp_fwd_res, exp_fwd_rd2;
  logic [31:0] exp_sub_zero;
  int lat, low, vcount;

  initial begin
    clk = 0; rst = 0; id_valid = 0;
    rd1 = 0; rd2 = 0; imm = 0; rb = 0; rd = 0; regdst = 0; alusrc = 0; aluop = 0;
    br = 0; mrd = 0; mwr = 0; m2r = 0; rwr = 0;
    fwd_a = 0; fwd_b = 0; mem_fwd = 0; wb_fwd = 0; mem_stall = 0; flush = 0;
`ifdef EX_FWD_EN
    exp_sub = 32'd0;          exp_sub_zero = 32'd1;
    exp_fwd_res = 32'd41;     exp_fwd_rd2 = 32'd40;
`else
    exp_sub = 32'hFFFF_FFF7;  exp_sub_zero = 32'd0;
    exp_fwd_res = 32'd2;      exp_fwd_rd2 = 32'd1;
`endif

    // Reset state
    tick(); tick();
    check("rst_valid",  32'(v_out), 32'd0);
    check("rst_result", res_out, 32'd0);
    check("rst_wreg",   32'(wreg_out), 32'd0);
    check("rst_rwr",    32'(rwr_out), 32'd0);
    check("rst_busy",   32'(busy), 32'd0);
    check("rst_ready",  32'(id_ready), 32'd0);
    rst = 1;

    // ADD 7 + imm 5 into Rd=3
    set_op(5'd0, 32'd7, 32'd0);
    imm = 32'd5; alusrc = 1; regdst = 1; rd = 5'd3; rb = 5'd9; rwr = 1;
    #1 check("add_ready", 32'(id_ready), 32'd1);
    tick();
    check("add_result", res_out, 32'd12);
    check("add_wreg",   32'(wreg_out), 32'd3);
    check("add_zero",   32'(zero_out), 32'd0);
    check("add_valid",  32'(v_out), 32'd1);
    check("add_rwr",    32'(rwr_out), 32'd1);

    // SUB with A forwarded from MEM
    set_op(5'd1, 32'd0, 32'd9);
    fwd_a = 2'd1; mem_fwd = 32'd9; regdst = 0; rb = 5'd4;
    tick();
    check("sub_result", res_out, exp_sub);
    check("sub_zero",   32'(zero_out), exp_sub_zero);
    check("sub_wreg",   32'(wreg_out), 32'd4);
    check("sub_rd2",    rd2_out, 32'd9);

    // Reserved select on A, WB forward on B
    set_op(5'd0, 32'd1, 32'd1);
    fwd_a = 2'd3; fwd_b = 2'd2; mem_fwd = 32'd100; wb_fwd = 32'd40;
    tick();
    check("fwd_result", res_out, exp_fwd_res);
    check("fwd_rd2",    rd2_out, exp_fwd_rd2);

    // Single-cycle opcode table
    for (int i = 0; i < 11; i++) begin
      set_op(t_op[i], t_a[i], t_b[i]);
      tick();
      check($sformatf("alu_tbl%0d", i), res_out, t_exp[i]);
      check($sformatf("alu_val%0d", i), 32'(v_out), 32'd1);
    end

    // Idle cycle loads a bubble
    id_valid = 0;
    tick();
    check("bubble_valid", 32'(v_out), 32'd0);
    check("bubble_rwr",   32'(rwr_out), 32'd0);

    // Multi-cycle ops
    regdst = 1; rd = 5'd7;
    run_mc(5'd16, 32'h1_0000, 32'h1_0000, lat, low);
    check("mul_latency", 32'(lat), 32'd33);
    check("mul_notready", 32'(low), 32'd33);
    check("mul_result", res_out, 32'd0);
    check("mul_zero",   32'(zero_out), 32'd1);
    check("mul_wreg",   32'(wreg_out), 32'd7);
    check("mul_rwr",    32'(rwr_out), 32'd1);
    run_mc(5'd17, 32'h1_0000, 32'h1_0000, lat, low);
    check("mulhu_result", res_out, 32'd1);
    check("mulhu_zero",   32'(zero_out), 32'd0);
    run_mc(5'd18, 32'd100, 32'd7, lat, low);
    check("divu_latency", 32'(lat), 32'd33);
    check("divu_result",  res_out, 32'd14);
    run_mc(5'd19, 32'd100, 32'd7, lat, low);
    check("remu_result",  res_out, 32'd2);
    run_mc(5'd18, 32'd5, 32'd0, lat, low);
    check("divz_latency", 32'(lat), 32'd33);
    check("divz_result",  res_out, 32'hFFFF_FFFF);
    run_mc(5'd19, 32'd5, 32'd0, lat, low);
    check("remz_result",  res_out, 32'd5);
    run_mc(5'd16, 32'd123, 32'd1000, lat, low);
    check("mul2_result",  res_out, 32'd123000);

    // Flush during BUSY
    set_op(5'd18, 32'd100, 32'd7);
    tick();
    id_valid = 0;
    repeat (10) tick();
    check("fl_busy", 32'(busy), 32'd1);
    flush = 1;
    tick();
    check("fl_valid", 32'(v_out), 32'd0);
    check("fl_idle",  32'(busy), 32'd0);
    check("fl_ready_during", 32'(id_ready), 32'd0);
    flush = 0;
    #1 check("fl_ready_after", 32'(id_ready), 32'd1);
    set_op(5'd0, 32'd2, 32'd3);
    tick();
    check("fl_add_result", res_out, 32'd5);
    check("fl_add_valid",  32'(v_out), 32'd1);
    id_valid = 0;
    vcount = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (v_out) vcount++;
    end
    check("fl_no_stale", 32'(vcount), 32'd0);

    // DONE held by mem_stall for 3 cycles
    set_op(5'd16, 32'd3, 32'd5);
    tick();
    id_valid = 0;
    repeat (32) tick();
    check("st_done_busy", 32'(busy), 32'd1);
    mem_stall = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("st_hold_v%0d", i), 32'(v_out), 32'd0);
      check($sformatf("st_hold_r%0d", i), res_out, 32'd0);
      check($sformatf("st_busy%0d", i), 32'(busy), 32'd1);
    end
    check("st_ready", 32'(id_ready), 32'd0);
    mem_stall = 0;
    tick();
    check("st_valid",  32'(v_out), 32'd1);
    check("st_result", res_out, 32'd15);

    // Reset while a single-cycle result is in EX/MEM
    set_op(5'd0, 32'd7, 32'd5);
    tick();
    id_valid = 0;
    rst = 0;
    tick();
    check("rs1_valid",  32'(v_out), 32'd0);
    check("rs1_result", res_out, 32'd0);
    check("rs1_wreg",   32'(wreg_out), 32'd0);
    rst = 1;

    // Reset mid-BUSY discards the op
    set_op(5'd16, 32'd9, 32'd9);
    tick();
    id_valid = 0;
    repeat (5) tick();
    check("rs2_busy_pre", 32'(busy), 32'd1);
    rst = 0;
    tick();
    check("rs2_busy",   32'(busy), 32'd0);
    check("rs2_valid",  32'(v_out), 32'd0);
    check("rs2_rwr",    32'(rwr_out), 32'd0);
    check("rs2_ready",  32'(id_ready), 32'd0);
    rst = 1;
    #1 check("rs2_ready_after", 32'(id_ready), 32'd1);
    vcount = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (v_out) vcount++;
    end
    check("rs2_no_stale", 32'(vcount), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
